// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit CPU control block.
//   - DATA_W: datapath width
//   - opcode values (IR[7:4]), ALU select codes, idle select code
//   - FSM state encoding
//   - helpers classifying opcodes and mapping them to ALU select codes
package cpu_pkg;

  localparam int DATA_W = 8;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_RST = 4'h1;
  localparam logic [3:0] OP_SHL = 4'h2;
  localparam logic [3:0] OP_LD  = 4'h3;
  localparam logic [3:0] OP_SHR = 4'h4;
  localparam logic [3:0] OP_NOR = 4'h5;
  localparam logic [3:0] OP_ADD = 4'h6;
  localparam logic [3:0] OP_SUB = 4'h7;
  localparam logic [3:0] OP_ST  = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_LDI = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [3:0] ALU_RST  = 4'b0000;
  localparam logic [3:0] ALU_SHL  = 4'b0001;
  localparam logic [3:0] ALU_LD   = 4'b0010;
  localparam logic [3:0] ALU_SHR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b1100;
  localparam logic [3:0] ALU_IDLE = 4'b0111;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_OPERAND   = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  // Opcodes 1..7 are the ALU operations.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_RST) && (op <= OP_SUB);
  endfunction

  // Jumps and LDI carry a second (operand) byte.
  function automatic logic has_operand(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC) || (op == OP_LDI);
  endfunction

  function automatic logic [3:0] alu_code(input logic [3:0] op);
    logic [3:0] code;
    case (op)
      OP_RST:  code = ALU_RST;
      OP_SHL:  code = ALU_SHL;
      OP_LD:   code = ALU_LD;
      OP_SHR:  code = ALU_SHR;
      OP_NOR:  code = ALU_NOR;
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      default: code = ALU_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: 4 x DATA_W general-purpose registers R0-R3.
//   clk, rst        clock, synchronous active-high reset (clears all registers)
//   we_i            write enable
//   waddr_i/wdata_i write address / data
//   raddr_a_i/b_i   two asynchronous read addresses
//   rdata_a_o/b_o   corresponding read data
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [1:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        raddr_a_i,
  input  logic [1:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/cpu_control.sv
// cpu_control: fetch/decode/execute sequencer and datapath registers.
//   clk, rst     clock, synchronous active-high reset
//   run          1 advances the FSM, 0 freezes all state and outputs
//   imem_addr    program memory address (PC, or PC+1 while fetching an operand)
//   imem_data    program memory read data (combinational from imem_addr)
//   alu_a/alu_b  ALU operands, latched in DECODE and held through WRITEBACK
//   alu_sel      ALU op select (idle code outside EXECUTE)
//   alu_en       ALU enable, high only in EXECUTE
//   alu_result/alu_cout/alu_zout  ALU outputs, captured in WRITEBACK
//   acc, flag_c, flag_z           accumulator and flag registers
//   halted       high while in HALT
module cpu_control
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_data,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [3:0]        alu_sel,
  output logic              alu_en,
  input  logic [7:0]        alu_result,
  input  logic              alu_cout,
  input  logic              alu_zout,
  output logic [7:0]        acc,
  output logic              flag_c,
  output logic              flag_z,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        acc_q, acc_d;
  logic              flag_c_q, flag_c_d;
  logic              flag_z_q, flag_z_d;
  logic [7:0]        alu_a_q, alu_a_d;
  logic [7:0]        alu_b_q, alu_b_d;

  logic              rf_we;
  logic [7:0]        rf_rdata_a, rf_rdata_b;
  logic [3:0]        opcode;
  logic [1:0]        rsel;
  logic              jump_taken;
  logic              unused_ir_bits;

  assign opcode = ir_q[7:4];
  assign rsel   = ir_q[1:0];
  // IR[3:2] carry no meaning in this instruction set.
  assign unused_ir_bits = ^ir_q[3:2];

  cpu_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (rf_we),
    .waddr_i   (rsel),
    .wdata_i   (acc_q),
    .raddr_a_i (rsel),
    .raddr_b_i (rsel),
    .rdata_a_o (rf_rdata_a),
    .rdata_b_o (rf_rdata_b)
  );

  // Conditional jumps look at the registered flags, never the live ALU outputs.
  always_comb begin
    case (opcode)
      OP_JMP:  jump_taken = 1'b1;
      OP_JZ:   jump_taken = flag_z_q;
      OP_JC:   jump_taken = flag_c_q;
      default: jump_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    acc_d    = acc_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    rf_we    = 1'b0;
    if (run) begin
      case (state_q)
        S_FETCH: begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          alu_a_d = (opcode == OP_LD) ? rf_rdata_a : acc_q;
          alu_b_d = rf_rdata_b;
          if (is_alu_op(opcode))        state_d = S_EXECUTE;
          else if (has_operand(opcode)) state_d = S_OPERAND;
          else if (opcode == OP_HLT)    state_d = S_HALT;
          else                          state_d = S_WRITEBACK;
        end
        S_EXECUTE: begin
          state_d = S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (is_alu_op(opcode)) begin
            acc_d    = alu_result;
            flag_c_d = alu_cout;
            flag_z_d = alu_zout;
          end
          rf_we   = (opcode == OP_ST);
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
        S_OPERAND: begin
          if (opcode == OP_LDI) begin
            acc_d    = imem_data;
            flag_z_d = (imem_data == 8'h00);
          end
          if (jump_taken) pc_d = ADDR_W'(imem_data);
          else            pc_d = pc_q + ADDR_W'(2);
          state_d = S_FETCH;
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      acc_q    <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      acc_q    <= acc_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
    end
  end

  // Outputs are decoded from registered state only, so a frozen FSM freezes them too.
  assign imem_addr = (state_q == S_OPERAND) ? pc_q + ADDR_W'(1) : pc_q;
  assign alu_en    = (state_q == S_EXECUTE);
  assign alu_sel   = (state_q == S_EXECUTE) ? alu_code(opcode) : ALU_IDLE;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign acc       = acc_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: small programs in a behavioural memory,
// a registered ALU model, and hand-computed expected values.
module tb_cpu_control;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_data;
  logic [7:0]        alu_a, alu_b;
  logic [3:0]        alu_sel;
  logic              alu_en;
  logic [7:0]        alu_result = 8'h00;
  logic              alu_cout = 1'b0;
  logic              alu_zout;
  logic [7:0]        acc;
  logic              flag_c, flag_z, halted;

  logic [7:0] mem [256];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  // ALU model: latches its result on the EXECUTE edge so it is stable in WRITEBACK.
  always @(posedge clk) begin
    if (alu_en) begin
      case (alu_sel)
        4'b0000: {alu_cout, alu_result} <= 9'h000;
        4'b0001: {alu_cout, alu_result} <= {alu_a, 1'b0};
        4'b0010: {alu_cout, alu_result} <= {1'b0, alu_a};
        4'b0011: {alu_cout, alu_result} <= {alu_a[0], 1'b0, alu_a[7:1]};
        4'b0100: {alu_cout, alu_result} <= {1'b0, ~(alu_a | alu_b)};
        4'b1000: {alu_cout, alu_result} <= {1'b0, alu_a} + {1'b0, alu_b};
        4'b1100: {alu_cout, alu_result} <= {1'b0, alu_a} - {1'b0, alu_b};
        default: {alu_cout, alu_result} <= 9'h000;
      endcase
    end
  end
  assign alu_zout = (alu_result == 8'h00);

  cpu_control #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_en     (alu_en),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .alu_zout   (alu_zout),
    .acc        (acc),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .halted     (halted)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int k;
    k = 0;
    while (!halted && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, {15'd0, halted}, 16'd1);
  endtask

  logic [3:0] exp_sel [8];
  logic       exp_en  [8];

  initial begin
    rst = 1'b1;
    run = 1'b1;

    // 1: LDI 5; ST R0; LDI 3; ADD R0; HLT
    clear_mem();
    mem[0] = 8'hC0; mem[1] = 8'h05; mem[2] = 8'h80;
    mem[3] = 8'hC0; mem[4] = 8'h03; mem[5] = 8'h60; mem[6] = 8'hF0;
    do_reset();
    check("rst_acc",    {8'd0, acc}, 16'h0000);
    check("rst_flags",  {14'd0, flag_c, flag_z}, 16'h0000);
    check("rst_halted", {15'd0, halted}, 16'h0000);
    check("rst_sel",    {12'd0, alu_sel}, 16'h0007);
    check("rst_en",     {15'd0, alu_en}, 16'h0000);
    check("rst_ab",     {alu_a, alu_b}, 16'h0000);
    check("rst_addr",   {8'd0, imem_addr}, 16'h0000);
    tick(14);
    check("t1_not_yet_halted", {15'd0, halted}, 16'h0000);
    tick(1);
    check("t1_halted", {15'd0, halted}, 16'h0001);
    check("t1_acc",    {8'd0, acc}, 16'h0008);
    check("t1_flags",  {14'd0, flag_c, flag_z}, 16'h0000);
    check("t1_addr",   {8'd0, imem_addr}, 16'h0006);
    tick(3);
    check("t1_hold_addr", {8'd0, imem_addr}, 16'h0006);
    check("t1_hold_acc",  {8'd0, acc}, 16'h0008);

    // 2: LDI 1; ST R1; LDI FF; ADD R1; JC 10 ; HLT at 0x10
    clear_mem();
    mem[0] = 8'hC0; mem[1] = 8'h01; mem[2] = 8'h81;
    mem[3] = 8'hC0; mem[4] = 8'hFF; mem[5] = 8'h61;
    mem[6] = 8'hB0; mem[7] = 8'h10;
    do_reset();
    wait_halt("t2_halt", 100);
    check("t2_acc",   {8'd0, acc}, 16'h0000);
    check("t2_flags", {14'd0, flag_c, flag_z}, 16'h0003);
    check("t2_addr",  {8'd0, imem_addr}, 16'h0010);

    // 3: LDI 5; ST R2; LDI 3; SUB R2; JZ 20 (not taken); HLT at 8
    clear_mem();
    mem[0] = 8'hC0; mem[1] = 8'h05; mem[2] = 8'h82;
    mem[3] = 8'hC0; mem[4] = 8'h03; mem[5] = 8'h72;
    mem[6] = 8'hA0; mem[7] = 8'h20; mem[8] = 8'hF0;
    mem[8'h20] = 8'h00;
    do_reset();
    wait_halt("t3_halt", 100);
    check("t3_acc",   {8'd0, acc}, 16'h00FE);
    check("t3_flags", {14'd0, flag_c, flag_z}, 16'h0002);
    check("t3_addr",  {8'd0, imem_addr}, 16'h0008);

    // 4: RST; RST; HLT -- alu_sel / alu_en per cycle
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h10; mem[2] = 8'hF0;
    exp_sel = '{4'h7, 4'h7, 4'h0, 4'h7, 4'h7, 4'h7, 4'h0, 4'h7};
    exp_en  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_sel%0d", i), {12'd0, alu_sel}, {12'd0, exp_sel[i]});
      check($sformatf("t4_en%0d", i),  {15'd0, alu_en}, {15'd0, exp_en[i]});
      if (i == 4) check("t4_z_first", {15'd0, flag_z}, 16'h0001);
      tick(1);
    end
    wait_halt("t4_halt", 20);
    check("t4_acc", {8'd0, acc}, 16'h0000);
    check("t4_z",   {15'd0, flag_z}, 16'h0001);

    // 5a: JMP FE; at FE: JMP with operand at FF -> 04; HLT at 04
    clear_mem();
    mem[0] = 8'h90; mem[1] = 8'hFE;
    mem[8'hFE] = 8'h90; mem[8'hFF] = 8'h04; mem[4] = 8'hF0;
    do_reset();
    tick(5);
    check("t5_operand_addr", {8'd0, imem_addr}, 16'h00FF);
    tick(1);
    check("t5_jump_target", {8'd0, imem_addr}, 16'h0004);
    wait_halt("t5_halt", 20);

    // 5b: JMP FF; NOP at FF -> PC wraps to 00
    clear_mem();
    mem[0] = 8'h90; mem[1] = 8'hFF; mem[8'hFF] = 8'h00;
    do_reset();
    tick(3);
    check("t5_at_ff", {8'd0, imem_addr}, 16'h00FF);
    tick(3);
    check("t5_wrap", {8'd0, imem_addr}, 16'h0000);

    // 6: LDI 5; ST R0; ADD R0; HLT -- reset during EXECUTE of ADD
    clear_mem();
    mem[0] = 8'hC0; mem[1] = 8'h05; mem[2] = 8'h80; mem[3] = 8'h60; mem[4] = 8'hF0;
    do_reset();
    tick(8);
    check("t6_in_exec_en",  {15'd0, alu_en}, 16'h0001);
    check("t6_in_exec_sel", {12'd0, alu_sel}, 16'h0008);
    check("t6_pre_acc",     {8'd0, acc}, 16'h0005);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_rst_acc",   {8'd0, acc}, 16'h0000);
    check("t6_rst_flags", {14'd0, flag_c, flag_z}, 16'h0000);
    check("t6_rst_addr",  {8'd0, imem_addr}, 16'h0000);
    check("t6_rst_en",    {15'd0, alu_en}, 16'h0000);
    check("t6_rst_a",     {8'd0, alu_a}, 16'h0000);
    wait_halt("t6_halt", 40);
    check("t6_acc", {8'd0, acc}, 16'h000A);

    // 6b: same program, run=0 for 3 cycles while in DECODE of the first LDI
    do_reset();
    tick(1);
    run = 1'b0;
    tick(3);
    check("t6_frozen_addr", {8'd0, imem_addr}, 16'h0000);
    check("t6_frozen_sel",  {12'd0, alu_sel}, 16'h0007);
    check("t6_frozen_acc",  {8'd0, acc}, 16'h0000);
    run = 1'b1;
    tick(1);
    check("t6_resume_operand", {8'd0, imem_addr}, 16'h0001);
    tick(9);
    check("t6_shift_not_halted", {15'd0, halted}, 16'h0000);
    tick(1);
    check("t6_shift_halted", {15'd0, halted}, 16'h0001);
    check("t6_shift_acc",    {8'd0, acc}, 16'h000A);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
